// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: fetch FSM states, NOP encoding, reset PC and PC step.
package pipe_pkg;
  typedef enum logic [1:0] {S_RESET, S_ISSUE, S_WAIT, S_HOLD} fetch_state_e;

  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  function automatic logic [31:0] word_addr(input logic [29:0] word);
    return {word, 2'b00};
  endfunction
endpackage

// File: rtl/if_skid_buf.sv
// One-entry holding buffer for a fetched instruction that decode could not take yet.
module if_skid_buf
  import pipe_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic        i_unload,
  input  logic        i_clear,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic        o_full
);
  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic        r_full;

  always_ff @(negedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_instr <= INSTR_NOP;
      r_pc    <= '0;
      r_full  <= 1'b0;
    end else if (i_clear) begin
      r_full  <= 1'b0;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_pc    <= i_pc;
      r_full  <= 1'b1;
    end else if (i_unload) begin
      r_full  <= 1'b0;
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_full  = r_full;
endmodule

// File: rtl/if_id_stage.sv
// Fetch stage + IF/ID register: single-outstanding imem fetch, skid on decode stall, EX redirects.
// Define IF_ID_PERF_EN to build the delivered-instruction and redirect counters.
module if_id_stage
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        CLK,
  input  logic        Resetn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall_ID,
  input  logic        redirect_EX,
  input  logic [31:0] redirect_PC,
  output logic [31:0] instr_ID,
  output logic [31:0] PC_ID,
  output logic        valid_ID,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_flush_cnt
);
  fetch_state_e r_state, w_state_nxt;
  logic [31:0]  r_pc, w_pc_nxt;
  logic         r_drop, w_drop_nxt;
  logic         w_deliver, w_from_skid, w_skid_load;
  logic [31:0]  w_redir_pc;
  logic [31:0]  w_skid_instr, w_skid_pc;
  logic         w_skid_full;
  logic         w_unused_redir_lsb;

  assign w_redir_pc         = word_addr(redirect_PC[31:2]);
  assign w_unused_redir_lsb = ^{redirect_PC[1:0], w_skid_full};

  assign imem_req  = (r_state == S_ISSUE);
  assign imem_addr = r_pc;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_drop_nxt  = r_drop;
    w_deliver   = 1'b0;
    w_from_skid = 1'b0;
    w_skid_load = 1'b0;
    case (r_state)
      S_RESET: begin
        w_state_nxt = S_ISSUE;
        if (redirect_EX) w_pc_nxt = w_redir_pc;
      end
      S_ISSUE: begin
        w_state_nxt = S_WAIT;
        // the request leaving this cycle is for the old path
        if (redirect_EX) begin
          w_pc_nxt   = w_redir_pc;
          w_drop_nxt = 1'b1;
        end
      end
      S_WAIT: begin
        if (redirect_EX) begin
          w_pc_nxt = w_redir_pc;
          if (imem_rvalid) begin
            w_drop_nxt  = 1'b0;
            w_state_nxt = S_ISSUE;
          end else begin
            w_drop_nxt  = 1'b1;
          end
        end else if (imem_rvalid) begin
          w_state_nxt = S_ISSUE;
          if (r_drop) begin
            w_drop_nxt = 1'b0;
          end else if (!stall_ID) begin
            w_deliver = 1'b1;
            w_pc_nxt  = r_pc + PC_STEP;
          end else begin
            w_skid_load = 1'b1;
            w_state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect_EX) begin
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = S_ISSUE;
        end else if (!stall_ID) begin
          w_deliver   = 1'b1;
          w_from_skid = 1'b1;
          w_pc_nxt    = r_pc + PC_STEP;
          w_state_nxt = S_ISSUE;
        end
      end
    endcase
  end

  always_ff @(negedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= S_RESET;
      r_pc    <= RESET_PC;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

  if_skid_buf u_skid (
    .i_clk    (CLK),
    .i_rst_n  (Resetn),
    .i_load   (w_skid_load),
    .i_unload (w_deliver & w_from_skid),
    .i_clear  (redirect_EX),
    .i_instr  (imem_rdata),
    .i_pc     (r_pc),
    .o_instr  (w_skid_instr),
    .o_pc     (w_skid_pc),
    .o_full   (w_skid_full)
  );

  // Redirect squashes even a stalled IF/ID; a bubble keeps the last PC_ID.
  always_ff @(negedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      instr_ID <= INSTR_NOP;
      PC_ID    <= '0;
      valid_ID <= 1'b0;
    end else if (redirect_EX) begin
      instr_ID <= INSTR_NOP;
      valid_ID <= 1'b0;
    end else if (w_deliver) begin
      instr_ID <= w_from_skid ? w_skid_instr : imem_rdata;
      PC_ID    <= w_from_skid ? w_skid_pc : r_pc;
      valid_ID <= 1'b1;
    end else if (!stall_ID) begin
      instr_ID <= INSTR_NOP;
      valid_ID <= 1'b0;
    end
  end

`ifdef IF_ID_PERF_EN
  logic [31:0] r_fetch_cnt, r_flush_cnt;

  always_ff @(negedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      r_fetch_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_deliver)   r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (redirect_EX) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign perf_fetch_cnt = r_fetch_cnt;
  assign perf_flush_cnt = r_flush_cnt;
`else
  assign perf_fetch_cnt = '0;
  assign perf_flush_cnt = '0;
`endif
endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: latency-programmable imem model feeding a delivery scoreboard.
module tb_if_id_stage;
  logic        CLK, Resetn;
  logic        imem_req, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        stall_ID, redirect_EX, valid_ID;
  logic [31:0] redirect_PC, instr_ID, PC_ID, perf_fetch_cnt, perf_flush_cnt;

  if_id_stage dut (
    .CLK(CLK), .Resetn(Resetn),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall_ID(stall_ID), .redirect_EX(redirect_EX), .redirect_PC(redirect_PC),
    .instr_ID(instr_ID), .PC_ID(PC_ID), .valid_ID(valid_ID),
    .perf_fetch_cnt(perf_fetch_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed { logic [31:0] instr; logic [31:0] pc; } exp_t;
  exp_t sb[$];

  int          errors = 0, checks = 0;
  int          n_deliv = 0, n_redir = 0;
  int          lat = 1, cnt = 0;
  bit          pend = 0, drop_next = 0, req_seen = 0;
  logic [31:0] pend_addr = '0, req_addr = '0;
  logic        pv = 1'b0;
  logic [31:0] ppc = '0, pins = '0;

  initial CLK = 1'b1;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0010_0093 + (a << 8);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One posedge: run the memory model, record requests, score new IF/ID deliveries.
  task automatic tick();
    exp_t e;
    @(posedge CLK);
    imem_rvalid = 1'b0;
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        pend        = 0;
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_addr);
        if (drop_next) drop_next = 0;
        else begin
          e.instr = mem_word(pend_addr);
          e.pc    = pend_addr;
          sb.push_back(e);
        end
      end
    end
    req_seen = imem_req;
    req_addr = imem_addr;
    if (imem_req) begin
      check("one_outstanding", 32'(pend), 32'd0);
      pend = 1; cnt = lat; pend_addr = imem_addr;
    end
    if (valid_ID && !(pv && ppc === PC_ID && pins === instr_ID)) begin
      n_deliv++;
      check("sb_has_entry", (sb.size() == 0) ? 32'd0 : 32'd1, 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("deliv_instr", instr_ID, e.instr);
        check("deliv_pc", PC_ID, e.pc);
      end
    end
    pv = valid_ID; ppc = PC_ID; pins = instr_ID;
  endtask

  task automatic expect_req(input string tag, input logic [31:0] a);
    int n = 0;
    do begin tick(); n++; end while (!req_seen && n < 50);
    check({tag, "_seen"}, 32'(req_seen), 32'd1);
    check(tag, req_addr, a);
  endtask

  task automatic pulse_redirect(input logic [31:0] t);
    redirect_EX = 1'b1;
    redirect_PC = t;
    n_redir++;
    tick();
    redirect_EX = 1'b0;
  endtask

  task automatic check_reset(input string p);
    check({p, "_req"},   32'(imem_req), 32'd0);
    check({p, "_instr"}, instr_ID, NOP);
    check({p, "_pc"},    PC_ID, 32'd0);
    check({p, "_valid"}, 32'(valid_ID), 32'd0);
    check({p, "_pfetch"}, perf_fetch_cnt, 32'd0);
    check({p, "_pflush"}, perf_flush_cnt, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Resetn = 1'b0; stall_ID = 1'b0; redirect_EX = 1'b0; redirect_PC = '0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    tick(); tick();
    check_reset("rst");
    Resetn = 1'b1;

    // first fetch and steady flow with 1-cycle memory
    expect_req("req_0", 32'h0);
    expect_req("req_4", 32'h4);
    check("first_instr", instr_ID, 32'h0010_0093);
    check("first_pc", PC_ID, 32'h0);
    check("first_valid", 32'(valid_ID), 32'd1);

    // stall while the 0x8 response returns: held in skid, IF/ID frozen
    expect_req("req_8", 32'h8);
    stall_ID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_req", 32'(imem_req), 32'd0);
      check("stall_pc", PC_ID, 32'h4);
      check("stall_valid", 32'(valid_ID), 32'd1);
    end
    stall_ID = 1'b0;
    lat = 3;
    expect_req("req_c", 32'hC);
    check("skid_pc", PC_ID, 32'h8);
    check("skid_instr", instr_ID, mem_word(32'h8));

    // redirect while waiting on a slow response; low target bits ignored
    expect_req("req_10", 32'h10);
    tick();
    drop_next = 1;
    pulse_redirect(32'h0000_0102);
    tick();
    check("redir_gap_req", 32'(imem_req), 32'd0);
    check("redir_gap_valid", 32'(valid_ID), 32'd0);
    expect_req("req_100", 32'h100);
    check("redir_bubble", 32'(valid_ID), 32'd0);
    lat = 1;

    // redirect + response + stall in the same cycle
    expect_req("req_104", 32'h104);
    stall_ID = 1'b1;
    drop_next = 1;
    pulse_redirect(32'h200);
    expect_req("req_200", 32'h200);
    check("sim_valid", 32'(valid_ID), 32'd0);
    check("sim_instr", instr_ID, NOP);
    check("sim_pc", PC_ID, 32'h100);
    stall_ID = 1'b0;

    // wrap-around of the PC
    expect_req("req_204", 32'h204);
    drop_next = 1;
    pulse_redirect(32'hFFFF_FFFC);
    expect_req("req_wrap_hi", 32'hFFFF_FFFC);
    expect_req("req_wrap_0", 32'h0);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sb.size() == 0) break;
    end
    check("sb_drained", 32'(sb.size()), 32'd0);

`ifdef IF_ID_PERF_EN
    check("perf_fetch", perf_fetch_cnt, 32'(n_deliv));
    check("perf_flush", perf_flush_cnt, 32'(n_redir));
`else
    check("perf_fetch", perf_fetch_cnt, 32'd0);
    check("perf_flush", perf_flush_cnt, 32'd0);
`endif

    // reset mid-operation; memory forgets the outstanding request
    Resetn = 1'b0;
    #1;
    check_reset("midrst");
    pend = 0; drop_next = 0; sb.delete();
    tick(); tick();
    Resetn = 1'b1;
    expect_req("req_after_rst", 32'h0);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/if_id_stage.md
# if_id_stage

Fetch stage and IF/ID pipeline register for the five-stage RISC-V core. It owns the PC, issues single-outstanding requests to instruction memory, and holds a fetched instruction in a one-entry skid buffer when decode stalls. It delivers `instr_ID`/`PC_ID`/`valid_ID` to the ID stage, and ID feeds the ID/EX register. It honours load-use stalls from the hazard unit and taken-branch/jump redirects resolved in EX.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC fetched first after reset.
- `CLK` in 1: core clock. All state updates occur on the falling edge, matching the other pipeline registers.
- `Resetn` in 1: asynchronous, active-low reset.
- `imem_req` out 1: one-cycle request pulse.
- `imem_addr` out 32: fetch address. Valid when `imem_req`=1.
- `imem_rvalid` in 1: response valid. Arrives at least 1 cycle after the request.
- `imem_rdata` in 32: instruction word. Valid with `imem_rvalid`.
- `stall_ID` in 1: ID cannot accept a new instruction, so IF/ID holds.
- `redirect_EX` in 1: taken branch or jump.
- `redirect_PC` in 32: target address. Valid with `redirect_EX`.
- `instr_ID` out 32: instruction to decode.
- `PC_ID` out 32: PC of `instr_ID`.
- `valid_ID` out 1: `instr_ID` is a real instruction, not a bubble.
- `perf_fetch_cnt` out 32: count of instructions delivered. See Configuration.
- `perf_flush_cnt` out 32: count of redirects. See Configuration.

## Operation
- **FSM states:** `S_RESET`, `S_ISSUE`, `S_WAIT`, `S_HOLD`. The FSM also keeps a `drop` flag meaning "the outstanding response is stale".
- **Reset values:** state=`S_RESET`, pc=`RESET_PC`, drop=0, `imem_req`=0, `instr_ID`=NOP `32'h0000_0013`, `PC_ID`=0, `valid_ID`=0, skid empty, counters 0.
- **`S_RESET`:** moves to `S_ISSUE` on the first edge after reset release.
- **`S_ISSUE`:** drives `imem_req`=1 and `imem_addr`=pc. Next state is `S_WAIT`.
- **`S_WAIT`, no `imem_rvalid`:** stays in `S_WAIT`.
- **`S_WAIT`, `imem_rvalid` with drop=1:** discards the data, clears drop, goes to `S_ISSUE`.
- **`S_WAIT`, `imem_rvalid` with drop=0 and `stall_ID`=0:** loads IF/ID with {rdata, pc, valid=1}, sets pc+=4, goes to `S_ISSUE`.
- **`S_WAIT`, `imem_rvalid` with drop=0 and `stall_ID`=1:** writes {rdata, pc} into the skid buffer, goes to `S_HOLD`.
- **`S_HOLD`:** when `stall_ID`=0, moves the skid contents into IF/ID, sets pc+=4, goes to `S_ISSUE`.
- **IF/ID register behaviour:**
  - `stall_ID`=1: holds its current value.
  - `stall_ID`=0 with no new instruction: loads a bubble (NOP, valid=0). `PC_ID` is unchanged.
- **Redirect** (highest priority, overrides stall):
  - Actions: pc←`redirect_PC`; IF/ID←bubble; skid cleared.
  - In `S_ISSUE`: drop←1, go to `S_WAIT`. The request issued this cycle is stale.
  - In `S_WAIT` without `imem_rvalid`: drop←1, stay in `S_WAIT`.
  - In `S_WAIT` with `imem_rvalid` in the same cycle: discard the data, go to `S_ISSUE`.
  - In `S_HOLD`: go to `S_ISSUE`.
  - In `S_RESET`: pc is updated and the FSM proceeds to `S_ISSUE` as normal.
- **Arithmetic:** pc+4 is 32-bit and wraps modulo 2^32 (`32'hFFFF_FFFC`→0). `redirect_PC[1:0]` is ignored and forced to 0.
- **Reset mid-operation:** all state returns to reset values immediately. Any response arriving after reset release is ignored while in `S_RESET`/`S_ISSUE`, and is treated as stale in `S_WAIT` only if drop is set. Memory must not answer requests issued before reset.

## Timing
- A response sampled at edge N appears on `instr_ID` after edge N. Fetch-to-decode latency is 1 cycle after `imem_rvalid`.
- Throughput: one instruction per (2 + memory latency − 1) cycles. With 1-cycle memory, one instruction every 2 cycles.
- There is only ever one outstanding request. `imem_req` is never asserted in `S_WAIT`/`S_HOLD`.
- After a redirect, the new target is requested at most 1 cycle later, or after the stale response returns.

## Configuration
- **`IF_ID_PERF_EN` defined:**
  - `perf_fetch_cnt` increments on each load of IF/ID with valid=1.
  - `perf_flush_cnt` increments on each cycle with `redirect_EX`=1.
  - Both are 32-bit wrapping counters, reset to 0.
- **Undefined:** both ports remain present and are tied to 0. No counter flops are synthesized.

## Structure
- **Shared `pipe_pkg`:**
  - Fetch state enum.
  - `INSTR_NOP` = `32'h0000_0013`.
  - Default `RESET_PC`.
  - `PC_STEP` = 4.
- **Sub-module `if_skid_buf`:** one-entry buffer {instr, pc, full} with load, unload, and clear inputs. The FSM, PC, and IF/ID register stay in the top module.

## Test plan
- **Reset and first fetch:** release `Resetn`, with a 1-cycle memory returning `32'h0010_0093` → first `imem_req` has addr=`0x0`. Then `instr_ID`=`32'h0010_0093`, `PC_ID`=0, `valid_ID`=1. Next request addr=`0x4`.
- **Stall into skid:** assert `stall_ID` for 3 cycles while the response for `0x8` returns → FSM enters `S_HOLD` and IF/ID is unchanged. On release, `PC_ID`=`0x8`, and the next request is `0xC`.
- **Redirect while waiting:** use a 3-cycle memory, fetch `0x10`, pulse `redirect_EX` with `redirect_PC`=`0x100` → the `0x10` response is discarded. The next request is `0x100`, and `valid_ID`=0 until the `0x100` instruction arrives.
- **Simultaneous events:** redirect and `imem_rvalid` in the same cycle with `stall_ID`=1 → IF/ID becomes a bubble. The next request is at the redirect target, with no skid load.
- **Wrap-around:** set pc via redirect to `32'hFFFF_FFFC` → the next request after delivery is at `0x0`.
- **Performance counters (`IF_ID_PERF_EN`):** 5 delivered instructions and 2 redirects → `perf_fetch_cnt`=5, `perf_flush_cnt`=2. Without the macro, both read 0.
